// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared Booth digit encoding and FSM state types
package booth_pkg;

  typedef enum logic [2:0] {
    DIG_ZERO_0 = 3'b000,
    DIG_P1_0   = 3'b001,
    DIG_P1_1   = 3'b010,
    DIG_P2     = 3'b011,
    DIG_M2     = 3'b100,
    DIG_M1_0   = 3'b101,
    DIG_M1_1   = 3'b110,
    DIG_ZERO_1 = 3'b111
  } booth_dig_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// rtl/booth_r4_seq_mul_if.sv - operand/result handshake bundle for booth_r4_seq_mul
interface booth_r4_seq_mul_if #(
  parameter int WIDTH = 8
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               signed_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [2*WIDTH-1:0] result_o;
  logic               busy_o;

  modport slave (
    input  in_valid_i, a_i, b_i, signed_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o
  );

  modport master (
    output in_valid_i, a_i, b_i, signed_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/booth_pp_gen.sv
// rtl/booth_pp_gen.sv - combinational radix-4 Booth partial-product selector
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] a_i,
  input  booth_dig_e   dig_i,
  output logic [W+1:0] pp_o
);

  logic [W+1:0] a_w;
  logic [W+1:0] a2_w;

  // a_i is already sign/zero extended, so its MSB carries the true sign
  assign a_w  = {{2{a_i[W-1]}}, a_i};
  assign a2_w = a_w << 1;

  always_comb begin
    pp_o = '0;
    case (dig_i)
      DIG_P1_0, DIG_P1_1: pp_o = a_w;
      DIG_P2:             pp_o = a2_w;
      DIG_M2:             pp_o = ~a2_w + (W+2)'(1);
      DIG_M1_0, DIG_M1_1: pp_o = ~a_w + (W+2)'(1);
      default:            pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// rtl/booth_r4_seq_mul.sv - sequential radix-4 Booth multiplier, one digit per clock
// Optional macro BOOTH_EARLY_TERM_EN: exit CALC once the remaining multiplier bits are uniform.
module booth_r4_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  booth_r4_seq_mul_if.slave bus
);

  localparam int N_DIG = WIDTH / 2 + 1;
  localparam int EW    = WIDTH + 2;
  localparam int PW    = EW + 2;
  localparam int AW    = 2 * WIDTH + 4;
  localparam int CW    = $clog2(N_DIG) + 1;

  state_e               state_q, state_d;
  logic [EW-1:0]        a_q, a_d;
  logic [EW-1:0]        b_q, b_d;
  logic                 bm1_q, bm1_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   res_q, res_d;

  booth_dig_e           dig;
  logic [PW-1:0]        pp;
  logic [AW-1:0]        pp_ext;
  logic [CW:0]          shamt;
  logic                 last_dig;
  logic                 rest_zero;

  // b_q is shifted right two bits per digit, so the live digit is always at the bottom
  assign dig      = booth_dig_e'({b_q[1], b_q[0], bm1_q});
  assign pp_ext   = {{(AW-PW){pp[PW-1]}}, pp};
  assign shamt    = {cnt_q, 1'b0};
  assign last_dig = (cnt_q == CW'(N_DIG - 1));

`ifdef BOOTH_EARLY_TERM_EN
  assign rest_zero = (&b_q[EW-1:1]) | ~(|b_q[EW-1:1]);
`else
  assign rest_zero = 1'b0;
`endif

  booth_pp_gen #(.W(EW)) u_pp_gen (
    .a_i   (a_q),
    .dig_i (dig),
    .pp_o  (pp)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bm1_d   = bm1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          a_d     = {{2{bus.signed_i & bus.a_i[WIDTH-1]}}, bus.a_i};
          b_d     = {{2{bus.signed_i & bus.b_i[WIDTH-1]}}, bus.b_i};
          bm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + (pp_ext << shamt);
        b_d   = {b_q[EW-1], b_q[EW-1], b_q[EW-1:2]};
        bm1_d = b_q[1];
        cnt_d = cnt_q + CW'(1);
        if (last_dig || rest_zero) begin
          res_d   = acc_d[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      bm1_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bm1_q   <= bm1_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.result_o    = res_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// tb/tb_booth_r4_seq_mul.sv - directed self-checking bench for booth_r4_seq_mul
module tb_booth_r4_seq_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passes = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mul_if #(.WIDTH(8)) bus ();

  booth_r4_seq_mul #(.WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [7:0] b, input logic s);
    logic [9:0] be;
    int         lat;
    logic       uni;
    be  = {{2{s & b[7]}}, b};
    lat = 6;
`ifdef BOOTH_EARLY_TERM_EN
    for (int i = 4; i >= 0; i--) begin
      uni = 1'b1;
      for (int j = 2 * i + 1; j <= 9; j++) begin
        if (be[j] != be[9]) uni = 1'b0;
      end
      if (uni) lat = i + 2;
    end
`endif
    return lat;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    int av;
    int bv;
    int p;
    av = s ? int'($signed(a)) : int'(a);
    bv = s ? int'($signed(b)) : int'(b);
    p  = av * bv;
    return p[15:0];
  endfunction

  // Launch one operation and wait for out_valid; leaves the result unconsumed.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    int lat;
    bus.in_valid_i = 1'b1;
    bus.a_i        = a;
    bus.b_i        = b;
    bus.signed_i   = s;
    chk({tag, "_rdy"}, 32'(bus.in_ready_o), 32'd1);
    tick();
    bus.in_valid_i = 1'b0;
    bus.a_i        = 8'($urandom);
    bus.b_i        = 8'($urandom);
    bus.signed_i   = 1'($urandom);
    lat = 1;
    while (!bus.out_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(b, s)));
    chk({tag, "_res"}, 32'(bus.result_o), 32'(ref_mul(a, b, s)));
  endtask

  task automatic consume(input string tag);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk({tag, "_ovld_clr"}, 32'(bus.out_valid_o), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    int          w;
    logic [7:0]  ra, rb;
    logic        rs;

    bus.in_valid_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.signed_i    = 1'b0;
    bus.out_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rdy",  32'(bus.in_ready_o),  32'd1);
    chk("rst_ovld", 32'(bus.out_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o),      32'd0);
    chk("rst_res",  32'(bus.result_o),    32'd0);

    launch(8'h80, 8'h80, 1'b1, "m128sq");
    chk("m128sq_val", 32'(bus.result_o), 32'h4000);
    consume("m128sq");
    chk("m128sq_rdy_after", 32'(bus.in_ready_o), 32'd1);

    launch(8'hFF, 8'hFF, 1'b0, "u255sq");
    chk("u255sq_val", 32'(bus.result_o), 32'hFE01);
    consume("u255sq");
    launch(8'hFF, 8'hFF, 1'b1, "m1sq");
    chk("m1sq_val", 32'(bus.result_o), 32'h0001);
    consume("m1sq");
    launch(8'hFF, 8'h01, 1'b1, "m1x1");
    chk("m1x1_val", 32'(bus.result_o), 32'hFFFF);
    consume("m1x1");
    launch(8'h7F, 8'h80, 1'b1, "p127xm128");
    chk("p127xm128_val", 32'(bus.result_o), 32'hC080);
    consume("p127xm128");

    launch(8'h03, 8'h01, 1'b1, "3x1");
    chk("3x1_val", 32'(bus.result_o), 32'h0003);
`ifdef BOOTH_EARLY_TERM_EN
    chk("3x1_lat_fixed", 32'(exp_lat(8'h01, 1'b1)), 32'd2);
`else
    chk("3x1_lat_fixed", 32'(exp_lat(8'h01, 1'b1)), 32'd6);
`endif
    consume("3x1");

    // Backpressure with stray in_valid pulses
    launch(8'h0C, 8'h0A, 1'b0, "bp");
    held = bus.result_o;
    chk("bp_val", 32'(held), 32'h0078);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_i = i[0];
      bus.a_i        = 8'h11;
      bus.b_i        = 8'h22;
      tick();
      chk("bp_ovld", 32'(bus.out_valid_o), 32'd1);
      chk("bp_hold", 32'(bus.result_o),    32'(held));
      chk("bp_rdy",  32'(bus.in_ready_o),  32'd0);
    end
    bus.in_valid_i = 1'b0;
    consume("bp");
    chk("bp_rdy_after", 32'(bus.in_ready_o), 32'd1);

    // Reset in the third CALC cycle
    bus.in_valid_i = 1'b1;
    bus.a_i        = 8'h55;
    bus.b_i        = 8'h33;
    bus.signed_i   = 1'b0;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    chk("midrst_busy_pre", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rdy",  32'(bus.in_ready_o),  32'd1);
    chk("midrst_ovld", 32'(bus.out_valid_o), 32'd0);
    chk("midrst_busy", 32'(bus.busy_o),      32'd0);
    chk("midrst_res",  32'(bus.result_o),    32'd0);
    launch(8'h03, 8'h05, 1'b0, "3x5");
    chk("3x5_val", 32'(bus.result_o), 32'h000F);
    consume("3x5");

    // Random pairs with random consumer stalls
    for (int n = 0; n < 1500; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      launch(ra, rb, rs, "rnd");
      w = $urandom_range(0, 3);
      for (int k = 0; k < w; k++) tick();
      chk("rnd_hold", 32'(bus.result_o), 32'(ref_mul(ra, rb, rs)));
      consume("rnd");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
